// File: rtl/iq_pkg.sv
// Shared I/Q definitions: DDS quadrant type, mixer coefficient lookup and
// the 1-bit to +/-1 helper used by both the receive and transmit mixers.
package iq_pkg;

    typedef logic signed [1:0] phase_t;

    // Coefficient sign flags: a set bit means that component is negated.
    typedef struct packed {
        logic neg_i;
        logic neg_q;
    } coef_t;

    function automatic coef_t mix_coef(input phase_t p);
        coef_t c;
        case (p)
            2'b00:   c = '{neg_i: 1'b0, neg_q: 1'b1};
            2'b01:   c = '{neg_i: 1'b1, neg_q: 1'b1};
            2'b10:   c = '{neg_i: 1'b1, neg_q: 1'b0};
            default: c = '{neg_i: 1'b0, neg_q: 1'b0};
        endcase
        return c;
    endfunction

    function automatic logic signed [1:0] to_signed(input logic b);
        return b ? 2'sd1 : -2'sd1;
    endfunction

endpackage

// File: rtl/sigma_delta_1bit.sv
// First-order sigma-delta modulator: signed input to 1-bit output whose
// ones density is (1 + din/FS)/2. Emits a toggling idle pattern when disabled.
module sigma_delta_1bit #(
    parameter int IN_WIDTH = 9,
    parameter int FS       = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic signed [IN_WIDTH-1:0] din,
    output logic                       dac
);

    localparam int AW = IN_WIDTH + 2;
    localparam logic signed [AW-1:0] FS_W = AW'(FS);

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_next;
    logic signed [AW-1:0] din_x;
    logic signed [AW-1:0] fb;
    logic                 idle;

    assign din_x    = {{2{din[IN_WIDTH-1]}}, din};
    assign fb       = dac ? FS_W : -FS_W;
    assign acc_next = acc + din_x - fb;

    // idle marks that the previous cycle was disabled, so the toggle
    // pattern always opens with a 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            dac  <= 1'b0;
            idle <= 1'b0;
        end else if (!en) begin
            acc  <= '0;
            dac  <= idle ? ~dac : 1'b1;
            idle <= 1'b1;
        end else begin
            acc  <= acc_next;
            dac  <= ~acc_next[AW-1];
            idle <= 1'b0;
        end
    end

endmodule

// File: rtl/iq_upconverter.sv
// Transmit I/Q upconverter: valid/ready sample intake with HOLD-clock
// interpolation, quadrant LO mixer and 1-bit sigma-delta output.
module iq_upconverter
    import iq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int HOLD  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  phase_t                  phase,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_i,
    input  logic signed [WIDTH-1:0] in_q,
    output logic                    dac,
    output logic                    underrun
);

    localparam int CW = $clog2(HOLD);
    localparam logic [CW-1:0] LAST = CW'(HOLD - 1);

    logic signed [WIDTH-1:0] i_r;
    logic signed [WIDTH-1:0] q_r;
    logic [CW-1:0]           cnt;
    logic                    active;
    logic                    accept;
    logic                    expire;

    assign in_ready = en && (!active || cnt == LAST);
    assign accept   = in_valid && in_ready;
    assign expire   = active && cnt == LAST;

    // Accept has priority over expiry, so back-to-back streaming never underruns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_r      <= '0;
            q_r      <= '0;
            cnt      <= '0;
            active   <= 1'b0;
            underrun <= 1'b0;
        end else if (!en) begin
            i_r      <= '0;
            q_r      <= '0;
            cnt      <= '0;
            active   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (accept) begin
                i_r    <= in_i;
                q_r    <= in_q;
                cnt    <= '0;
                active <= 1'b1;
            end else if (expire) begin
                i_r      <= '0;
                q_r      <= '0;
                cnt      <= '0;
                active   <= 1'b0;
                underrun <= 1'b1;
            end else if (active) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Mixer: one extra bit so negating the most negative sample is exact.
    coef_t                 coef;
    logic signed [WIDTH:0] i_x;
    logic signed [WIDTH:0] q_x;
    logic signed [WIDTH:0] m_next;
    logic signed [WIDTH:0] m_r;

    assign coef   = mix_coef(phase);
    assign i_x    = {i_r[WIDTH-1], i_r};
    assign q_x    = {q_r[WIDTH-1], q_r};
    assign m_next = (coef.neg_i ? -i_x : i_x) + (coef.neg_q ? -q_x : q_x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r <= '0;
        end else if (!en) begin
            m_r <= '0;
        end else begin
            m_r <= m_next;
        end
    end

    sigma_delta_1bit #(
        .IN_WIDTH(WIDTH + 1),
        .FS      (2 ** WIDTH)
    ) u_sd (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .din  (m_r),
        .dac  (dac)
    );

endmodule

// File: tb/tb_iq_upconverter.sv
// Self-checking bench for iq_upconverter against a behavioural model of the
// stream, mixer and sigma-delta rules, with directed and random stimulus.
module tb_iq_upconverter;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int FS = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [1:0]        phase;
    logic              in_valid;
    logic              in_ready;
    logic signed [W-1:0] in_i;
    logic signed [W-1:0] in_q;
    logic              dac;
    logic              underrun;

    iq_upconverter #(.WIDTH(W), .HOLD(H)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .phase   (phase),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_i    (in_i),
        .in_q    (in_q),
        .dac     (dac),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    int hi, hq, age, busy, mm, macc, mdac, midle, munr;
    int cyc, last_acc_cyc, unr_cyc, unr_cnt, ones;

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int wrap9(input int x);
        int r;
        r = x & 511;
        if (r >= 256) r -= 512;
        return r;
    endfunction

    function automatic int mix(input int ph, input int i, input int q);
        int ci, cq;
        ci = (ph == 0 || ph == 3) ? 1 : -1;
        cq = (ph == 2 || ph == 3) ? 1 : -1;
        return wrap9(ci * i + cq * q);
    endfunction

    task automatic model_reset();
        hi = 0; hq = 0; age = 0; busy = 0; mm = 0;
        macc = 0; mdac = 0; midle = 0; munr = 0;
    endtask

    // Runs one clock with the inputs currently applied; checks before and after the edge.
    task automatic cycle();
        int exp_ready, acc_now, n_m, n_acc, n_dac;
        #1;
        exp_ready = (en && (!busy || age == H - 1)) ? 1 : 0;
        chk("in_ready", in_ready, exp_ready);
        acc_now = (exp_ready && in_valid) ? 1 : 0;
        if (!en) begin
            n_m = 0; n_acc = 0;
            n_dac = midle ? 1 - mdac : 1;
            midle = 1;
            hi = 0; hq = 0; age = 0; busy = 0; munr = 0;
        end else begin
            n_m   = mix(int'(phase), hi, hq);
            n_acc = macc + mm - (mdac ? FS : -FS);
            n_dac = (n_acc >= 0) ? 1 : 0;
            midle = 0;
            munr  = 0;
            if (acc_now) begin
                hi = int'(in_i); hq = int'(in_q); age = 0; busy = 1;
            end else if (busy && age == H - 1) begin
                hi = 0; hq = 0; age = 0; busy = 0; munr = 1;
            end else if (busy) begin
                age++;
            end
        end
        mm = n_m; macc = n_acc; mdac = n_dac;
        @(posedge clk);
        cyc++;
        if (acc_now) last_acc_cyc = cyc;
        #1;
        chk("m_r", int'(dut.m_r), mm);
        chk("dac", dac, mdac);
        chk("underrun", underrun, munr);
        if (underrun === 1'b1) begin
            unr_cnt++;
            unr_cyc = cyc;
        end
        ones += (dac === 1'b1) ? 1 : 0;
    endtask

    task automatic drive(input int v, input int i, input int q, input int ph);
        in_valid = v[0];
        in_i     = W'(i);
        in_q     = W'(q);
        phase    = 2'(ph);
    endtask

    task automatic density(input string tag, input int lo, input int hi_lim);
        for (int k = 0; k < 32; k++) cycle();
        ones = 0;
        for (int k = 0; k < 256; k++) cycle();
        chk(tag, (ones >= lo && ones <= hi_lim) ? 1 : 0, 1);
    endtask

    initial begin
        cyc = 0; unr_cnt = 0; ones = 0; last_acc_cyc = 0; unr_cyc = 0;
        model_reset();
        rst_n = 1'b0; en = 1'b1;
        drive(0, 0, 0, 0);
        #12;
        chk("rst_dac", dac, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_acc", int'(dut.u_sd.acc), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // mixer signs, I only then Q only
        for (int k = 0; k < 8; k++) begin
            drive(1, 127, 0, k % 4);
            cycle();
        end
        for (int k = 0; k < 8; k++) begin
            drive(1, 0, 100, k % 4);
            cycle();
        end

        // ones density
        drive(1, 64, 0, 0);
        density("density_p64", 159, 161);
        drive(1, -128, 0, 1);
        density("density_m128", 191, 193);

        // streaming handshake: one accept per H clocks, no underrun
        unr_cnt = 0;
        begin
            int nacc = 0;
            for (int k = 0; k < 10 * H; k++) begin
                drive(1, $urandom_range(255) - 128, $urandom_range(255) - 128, $urandom_range(3));
                #1;
                nacc += in_ready ? 1 : 0;
                cycle();
            end
            chk("stream_accepts", nacc, 10);
            chk("stream_no_unr", unr_cnt, 0);
        end

        // underrun after a single sample
        drive(0, 0, 0, 0);
        for (int k = 0; k < 2 * H; k++) cycle();
        unr_cnt = 0;
        drive(1, 90, -40, 2);
        cycle();
        drive(0, 0, 0, 2);
        for (int k = 0; k < 4 * H; k++) cycle();
        chk("unr_once", unr_cnt, 1);
        chk("unr_delay", unr_cyc - last_acc_cyc, H);
        density("density_zero", 127, 129);
        drive(1, 10, 20, 3);
        #1;
        chk("ready_after_unr", in_ready, 1);
        cycle();

        // enable drop mid-hold: idle toggle, no underrun
        unr_cnt = 0;
        drive(1, 50, 50, 0);
        cycle();
        en = 1'b0;
        #1;
        chk("en_low_ready", in_ready, 0);
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("idle_dac", dac, (k % 2 == 0) ? 1 : 0);
        end
        chk("idle_no_unr", unr_cnt, 0);
        en = 1'b1;
        drive(1, -70, 33, 1);
        #1;
        chk("en_rise_ready", in_ready, 1);
        cycle();
        for (int k = 0; k < 2 * H; k++) cycle();

        // random traffic
        for (int k = 0; k < 2000; k++) begin
            en = ($urandom_range(15) != 0);
            drive(($urandom_range(3) != 0) ? 1 : 0,
                  $urandom_range(255) - 128, $urandom_range(255) - 128, $urandom_range(3));
            cycle();
        end

        // async reset between edges
        en = 1'b1;
        drive(1, 100, 0, 0);
        for (int k = 0; k < 6; k++) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dac", dac, 0);
        chk("arst_underrun", underrun, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_acc", int'(dut.u_sd.acc), 0);
        chk("arst_m", int'(dut.m_r), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            drive(($urandom_range(1) != 0) ? 1 : 0,
                  $urandom_range(255) - 128, $urandom_range(255) - 128, $urandom_range(3));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
